// File: rtl/cla_adder_pipe.sv
// ============================================================================
//  Module      : cla_adder_pipe
//  Description : Parametrised, pipelined carry-lookahead adder/subtractor.
//                BLOCK-bit CLA groups with group-level lookahead. The group
//                chain is split evenly across STAGES registered stages.
//                Valid/ready handshakes are on both sides. The block reports
//                carry-out, signed overflow and zero flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cla_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG  = WIDTH / BLOCK;   // number of CLA groups
  localparam int GPS = NG / STAGES;     // groups resolved per stage
  localparam int SB  = GPS * BLOCK;     // bits resolved per stage

  // Operand conditioning: subtraction is A + ~B + ~borrow_in.
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_p_in;
  logic [WIDTH-1:0] w_g_in;
  logic             w_c0;

  assign w_b_eff = sub ? ~b : b;
  assign w_p_in  = a ^ w_b_eff;
  assign w_g_in  = a & w_b_eff;
  assign w_c0    = cin ^ sub;

  // Pipeline occupancy and flow control.
  logic [STAGES-1:0] r_v;      // stage holds a live op
  logic [STAGES-1:0] w_ld;     // stage may take new content this cycle
  logic [STAGES-1:0] w_src_v;  // valid bit offered to each stage
  logic [STAGES-1:0] w_en;     // stage actually captures an op

  // Back-pressure chain from the output toward the input: a stage can load
  // when it is empty or its own content leaves in the same cycle.
  always_comb begin : p_handshake
    logic chain;
    w_ld    = '0;
    w_src_v = '0;
    chain   = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      w_ld[s] = ~r_v[s] | chain;
      chain   = w_ld[s];
    end
    w_src_v[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      w_src_v[s] = r_v[s-1];
    end
    w_en = w_ld & w_src_v;
  end

  // Valid bits follow their data; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
    end else begin
      r_v <= (w_ld & w_src_v) | (~w_ld & r_v);
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * SB;        // first bit resolved here
    localparam int HI = LO + SB;       // one past last bit resolved here

    logic [WIDTH-1:LO] w_src_p;        // P/G still pending on entry
    logic [WIDTH-1:LO] w_src_g;
    logic              w_src_c;        // carry into bit LO
    logic [HI-1:0]     w_full_sum;     // all sum bits known after this stage

    logic [SB-1:0]     w_p;
    logic [SB-1:0]     w_g;
    logic [SB-1:0]     w_bc;           // carry into each local bit
    logic [SB-1:0]     w_snew;
    logic [GPS-1:0]    w_gp;           // group propagate
    logic [GPS-1:0]    w_gg;           // group generate
    logic [GPS:0]      w_gc;           // carry into each local group (+ out)

    logic [HI-1:0]     r_sum;
    logic              r_c;            // carry into bit HI

    if (s == 0) begin : g_src_in
      assign w_src_p    = w_p_in;
      assign w_src_g    = w_g_in;
      assign w_src_c    = w_c0;
      assign w_full_sum = w_snew;
    end else begin : g_src_prev
      assign w_src_p    = g_stage[s-1].g_pend.r_p;
      assign w_src_g    = g_stage[s-1].g_pend.r_g;
      assign w_src_c    = g_stage[s-1].r_c;
      assign w_full_sum = {w_snew, g_stage[s-1].r_sum};
    end

    assign w_p    = w_src_p[HI-1:LO];
    assign w_g    = w_src_g[HI-1:LO];
    assign w_snew = w_p ^ w_bc;

    // Two-level lookahead: every carry is a flat sum of products of the
    // group (or bit) generate/propagate terms and the stage carry-in.
    always_comb begin : p_lookahead
      logic t;
      w_gp = '0;
      w_gg = '0;
      w_gc = '0;
      w_bc = '0;
      t    = 1'b0;
      for (int k = 0; k < GPS; k++) begin
        w_gp[k] = &w_p[k*BLOCK +: BLOCK];
        for (int j = 0; j < BLOCK; j++) begin
          t = w_g[k*BLOCK + j];
          for (int m = j + 1; m < BLOCK; m++) t = t & w_p[k*BLOCK + m];
          w_gg[k] = w_gg[k] | t;
        end
      end
      for (int k = 0; k <= GPS; k++) begin
        t = w_src_c;
        for (int m = 0; m < k; m++) t = t & w_gp[m];
        w_gc[k] = t;
        for (int j = 0; j < k; j++) begin
          t = w_gg[j];
          for (int m = j + 1; m < k; m++) t = t & w_gp[m];
          w_gc[k] = w_gc[k] | t;
        end
      end
      for (int k = 0; k < GPS; k++) begin
        for (int i = 0; i < BLOCK; i++) begin
          t = w_gc[k];
          for (int m = 0; m < i; m++) t = t & w_p[k*BLOCK + m];
          w_bc[k*BLOCK + i] = t;
          for (int j = 0; j < i; j++) begin
            t = w_g[k*BLOCK + j];
            for (int m = j + 1; m < i; m++) t = t & w_p[k*BLOCK + m];
            w_bc[k*BLOCK + i] = w_bc[k*BLOCK + i] | t;
          end
        end
      end
    end

    // Capture the resolved sum bits and the carry handed to the next stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sum <= '0;
        r_c   <= 1'b0;
      end else if (w_en[s]) begin
        r_sum <= w_full_sum;
        r_c   <= w_gc[GPS];
      end
    end

    if (s < STAGES - 1) begin : g_pend
      logic [WIDTH-1:HI] r_p;
      logic [WIDTH-1:HI] r_g;

      // Forward the still-unresolved propagate/generate bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_p <= '0;
          r_g <= '0;
        end else if (w_en[s]) begin
          r_p <= w_src_p[WIDTH-1:HI];
          r_g <= w_src_g[WIDTH-1:HI];
        end
      end
    end else begin : g_flags
      logic r_ovf;
      logic r_zero;

      // Flags are registered together with the final sum.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_en[s]) begin
          r_ovf  <= w_bc[SB-1] ^ w_gc[GPS];
          r_zero <= ~|w_full_sum;
        end
      end
    end
  end

  assign in_ready  = w_ld[0];
  assign out_valid = r_v[STAGES-1];
  assign sum       = g_stage[STAGES-1].r_sum;
  assign cout      = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_flags.r_ovf;
  assign zero      = g_stage[STAGES-1].g_flags.r_zero;

endmodule

`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
// ============================================================================
//  Module      : tb_cla_adder_pipe
//  Description : Self-checking bench for cla_adder_pipe (16/4/2). Results are
//                scored against an arithmetic reference model held in a queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cla_adder_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  typedef struct {
    logic [18:0] res;    // {cout, ovf, zero, sum}
    int          acc;    // cycle the op was accepted
    bit          timed;  // latency must be exactly 2
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   fired;
  bit   check_lat;

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(16), .BLOCK(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: A+B+cin or A-B-cin, flags from the true result.
  function automatic logic [18:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci, input logic sb);
    int ux, uy, sx, sy, c, r, s;
    logic co, ov;
    logic [15:0] rs;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    c  = ci ? 1 : 0;
    if (!sb) begin
      r  = ux + uy + c;
      s  = sx + sy + c;
      co = (r > 65535);
    end else begin
      r  = ux - uy - c;
      s  = sx - sy - c;
      co = (r >= 0);
    end
    ov = (s > 32767) || (s < -32768);
    rs = r[15:0];
    return {co, ov, (rs == 16'h0000), rs};
  endfunction

  task automatic new_op();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // One clock cycle: score both handshakes just before the edge, then advance.
  task automatic step();
    @(negedge clk);
    fired = in_valid & in_ready & ~rst;
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        check_eq("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        check_eq("result", 32'({cout, ovf, zero, sum}), 32'(q[0].res));
        if (out_ready) begin
          if (q[0].timed) check_eq("latency", 32'(cyc - q[0].acc), 32'd2);
          void'(q.pop_front());
        end
      end
    end
    if (fired) q.push_back('{res: ref_model(a, b, cin, sub), acc: cyc, timed: check_lat});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check_eq("drain_empty", 32'(q.size()), 32'd0);
  endtask

  logic [15:0] da [6] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0009};
  logic [15:0] db [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0003};
  logic        dc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        ds [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepted;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    check_lat = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_state", 32'({out_valid, in_ready, cout, ovf, zero, sum}), 32'({2'b01, 3'b000, 16'h0000}));

    // Directed corner cases, back to back.
    for (int i = 0; i < 6; i++) begin
      a = da[i]; b = db[i]; cin = dc[i]; sub = ds[i];
      in_valid = 1'b1;
      step();
      check_eq("dir_accept", 32'(fired), 32'd1);
    end
    drain();

    // Streaming random ops at full rate.
    in_valid = 1'b1;
    new_op();
    for (int i = 0; i < 100; i++) begin
      check_eq("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      new_op();
    end
    drain();

    // Output stalled: only pipeline capacity is accepted, outputs hold.
    check_lat = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    accepted  = 0;
    new_op();
    for (int i = 0; i < 5; i++) begin
      step();
      if (fired) begin
        accepted++;
        new_op();
      end
    end
    check_eq("stall_accepts", 32'(accepted), 32'd2);
    check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    drain();

    // Reset with two ops in flight flushes them.
    check_lat = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    new_op();
    step();
    new_op();
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    check_eq("flush_state", 32'({out_valid, in_ready, cout, ovf, zero, sum}), 32'({2'b01, 3'b000, 16'h0000}));
    out_ready = 1'b1;
    repeat (4) step();
    in_valid = 1'b1;
    new_op();
    step();
    check_eq("post_reset_accept", 32'(fired), 32'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
